// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC request/priority path.
// Pure declarations: no latency, no flow control.
package pic_pkg;

  localparam int NUM_IR = 8;
  localparam logic [2:0] SPURIOUS_IR = 3'd7;

  typedef enum logic {IDLE, ACK1} ack_state_t;

  // Distance from the current highest-priority level; 0 is most urgent.
  function automatic logic [2:0] rank(input logic [2:0] ir, input logic [2:0] base);
    return ir - base;
  endfunction

endpackage

// File: rtl/pic_irr_resolver_if.sv
// Request/acknowledge bundle between PIC control logic (master) and the resolver (slave).
// No storage; backpressure is the INTA handshake carried on inta_pulse/ack_busy.
interface pic_irr_resolver_if;
  import pic_pkg::*;

  logic [NUM_IR-1:0] ir_in;
  logic              level_mode;
  logic [NUM_IR-1:0] imr;
  logic [NUM_IR-1:0] isr_cur;
  logic              init;
  logic              inta_pulse;
  logic              rotate_req;
  logic [2:0]        rotate_lowest;
  logic              int_out;
  logic [NUM_IR-1:0] isr_set;
  logic [2:0]        prio_base;
  logic [2:0]        vector_ir;
  logic [NUM_IR-1:0] irr;
  logic              ack_busy;

  modport master (
    output ir_in, level_mode, imr, isr_cur, init, inta_pulse, rotate_req, rotate_lowest,
    input  int_out, isr_set, prio_base, vector_ir, irr, ack_busy
  );

  modport slave (
    input  ir_in, level_mode, imr, isr_cur, init, inta_pulse, rotate_req, rotate_lowest,
    output int_out, isr_set, prio_base, vector_ir, irr, ack_busy
  );

endinterface

// File: rtl/pic_prio_encoder.sv
// Rotating priority encoder: index of the set bit nearest to base (wrapping upward).
// Purely combinational, zero latency; no flow control.
module pic_prio_encoder (
  input  logic [7:0] vec,
  input  logic [2:0] base,
  output logic       found,
  output logic [2:0] idx
);

  logic [2:0] probe;

  // Scan from the lowest priority upward so the last hit is the most urgent.
  always_comb begin
    found = |vec;
    idx   = '0;
    probe = '0;
    for (int k = 7; k >= 0; k--) begin
      probe = base + 3'(k);
      if (vec[probe]) idx = probe;
    end
  end

endmodule

// File: rtl/pic_irr_resolver.sv
// IRR capture, rotating priority resolution against the in-service set, and the two-pulse INTA sequence.
// ir_in to irr SYNC_STAGES+1 cycles, irr to int_out 1 cycle; INT is held low while an acknowledge is open.
module pic_irr_resolver #(
  parameter int NUM_IR      = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst_n,
  pic_irr_resolver_if.slave irq
);
  import pic_pkg::*;

  logic [NUM_IR-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IR-1:0] ir_s;
  logic [NUM_IR-1:0] ir_prev;
  logic [NUM_IR-1:0] irr_q;
  logic [NUM_IR-1:0] irr_d;
  logic [NUM_IR-1:0] irr_masked;
  logic [NUM_IR-1:0] ack_clr;
  logic [NUM_IR-1:0] isr_set_q;
  logic [2:0]        lowest_q;
  logic [2:0]        prio_base;
  logic [2:0]        win_idx;
  logic [2:0]        top_idx;
  logic [2:0]        vector_q;
  logic              win_found;
  logic              top_found;
  logic              pending;
  logic              first_ack;
  logic              int_q;
  ack_state_t        state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= irq.ir_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign ir_s       = sync_q[SYNC_STAGES-1];
  assign prio_base  = lowest_q + 3'd1;
  assign irr_masked = irr_q & ~irq.imr;

  pic_prio_encoder u_req_enc (
    .vec   (irr_masked),
    .base  (prio_base),
    .found (win_found),
    .idx   (win_idx)
  );

  pic_prio_encoder u_isr_enc (
    .vec   (irq.isr_cur),
    .base  (prio_base),
    .found (top_found),
    .idx   (top_idx)
  );

  // Only a strictly more urgent request may interrupt the level in service.
  assign pending   = win_found && (!top_found || (rank(win_idx, prio_base) < rank(top_idx, prio_base)));
  assign first_ack = (state == IDLE) && irq.inta_pulse;
  assign ack_clr   = (first_ack && pending) ? (NUM_IR'(1) << win_idx) : '0;

  always_comb begin
    irr_d = irq.level_mode ? ir_s : ((irr_q | (ir_s & ~ir_prev)) & ir_s);
    irr_d = irr_d & ~ack_clr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_prev   <= '0;
      irr_q     <= '0;
      lowest_q  <= 3'd7;
      state     <= IDLE;
      int_q     <= 1'b0;
      isr_set_q <= '0;
      vector_q  <= SPURIOUS_IR;
    end else if (irq.init) begin
      // A line already high must drop and rise again before it counts as an edge.
      ir_prev   <= '1;
      irr_q     <= '0;
      lowest_q  <= 3'd7;
      state     <= IDLE;
      int_q     <= 1'b0;
      isr_set_q <= '0;
    end else begin
      ir_prev   <= ir_s;
      irr_q     <= irr_d;
      isr_set_q <= ack_clr;
      if (irq.rotate_req) lowest_q <= irq.rotate_lowest;
      case (state)
        IDLE: begin
          int_q <= pending & ~irq.inta_pulse;
          if (irq.inta_pulse) begin
            state    <= ACK1;
            vector_q <= pending ? win_idx : SPURIOUS_IR;
          end
        end
        ACK1: begin
          int_q <= pending & irq.inta_pulse;
          if (irq.inta_pulse) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq.int_out   = int_q;
  assign irq.isr_set   = isr_set_q;
  assign irq.prio_base = prio_base;
  assign irq.vector_ir = vector_q;
  assign irq.irr       = irr_q;
  assign irq.ack_busy  = (state == ACK1);

endmodule

// File: doc/pic_irr_resolver.md
# pic_irr_resolver

Interrupt request register and rotating priority resolver for the 8-input PIC. It sits directly upstream of the in-service register. The block:
- synchronises the raw IR lines and captures requests in edge or level mode;
- masks requests with IMR and picks the highest-priority pending request under the current rotation;
- compares that request against the current in-service set and drives INT;
- runs the two-pulse INTA acknowledge sequence, emitting a one-hot set pulse and the priority base consumed by the ISR.

## Interface
Parameters:
- `NUM_IR`, 8, number of request lines (only 8 supported)
- `SYNC_STAGES`, 2, synchroniser depth on `ir_in`

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ir_in`  in  8  raw interrupt request lines, asynchronous
- `level_mode`  in  1  1 = level-triggered (LTIM), 0 = edge-triggered
- `imr`  in  8  interrupt mask; 1 masks the line
- `isr_cur`  in  8  current in-service bits fed back from the ISR
- `init`  in  1  one-cycle synchronous clear, pulsed on ICW1 write
- `inta_pulse`  in  1  one-cycle pulse per INTA falling edge, from control logic
- `rotate_req`  in  1  one-cycle pulse: load new lowest-priority level
- `rotate_lowest`  in  3  IR number that becomes lowest priority
- `int_out`  out  1  interrupt request to CPU
- `isr_set`  out  8  one-hot, one-cycle set pulse to the ISR
- `prio_base`  out  3  highest-priority IR number (`n` for ISR rotation)
- `vector_ir`  out  3  IR number acknowledged in the current or last INTA sequence
- `irr`  out  8  IRR contents for read-back
- `ack_busy`  out  1  high between first and second INTA

## Operation
- **Sync:** `ir_in` passes through `SYNC_STAGES` flops, giving `ir_s`. `ir_prev` holds the previous `ir_s`.
- **Edge mode:** an IRR bit sets on `ir_s & ~ir_prev`. It clears when `ir_s` goes low (request withdrawn) or when the bit is acknowledged.
- **Level mode:** each cycle, IRR loads `ir_s`. In the acknowledge cycle the acknowledged bit loads 0.
- **Rank:** rank(i) = (i − `prio_base`) mod 8, computed as a 3-bit wrapping subtraction. Rank 0 is highest priority.
- **Priority base:** `lowest_q` is reset to 7. `prio_base` = `lowest_q` + 1 mod 8. A `rotate_req` pulse loads `lowest_q` ← `rotate_lowest`.
- **Winner:** the minimum-rank set bit of `irr & ~imr`. `isr_top` is the minimum-rank set bit of `isr_cur`.
- **Pending:** a winner exists and either `isr_cur` == 0 or rank(winner) < rank(`isr_top`). A request of equal or lower priority than the in-service level never raises INT.
- **FSM states:** `IDLE`, `ACK1`.
  - **`IDLE` with `inta_pulse` and pending:**
    - go to `ACK1`;
    - latch the winner into `vector_ir`;
    - pulse `isr_set` = 1 << winner;
    - clear that IRR bit.
  - **`IDLE` with `inta_pulse` and no pending (request withdrawn):**
    - go to `ACK1`;
    - `vector_ir` = 7 (spurious IR7);
    - `isr_set` = 0;
    - IRR unchanged.
  - **`ACK1` with `inta_pulse`:** go to `IDLE`. `vector_ir` holds its value.
- **INT:** `int_out` = registered pending, forced 0 while in `ACK1`.
- **`init`:**
  - clear IRR;
  - set `ir_prev` to all-ones, so a line must go low and then high before an edge-mode request is captured;
  - `lowest_q` = 7;
  - FSM → `IDLE`.
- **Simultaneous events:**
  - `rotate_req` with `inta_pulse`: the winner uses the old base; the new base applies next cycle.
  - A new edge on the bit being acknowledged in the same cycle: the clear wins.
  - `init` with `inta_pulse`: `init` wins.
  - `imr` changing during `ACK1` does not affect the latched `vector_ir`.
- **Reset mid-sequence:** returns to `IDLE`. The next INTA pulse is treated as a first pulse.

## Timing
- **Reset values:**
  - `int_out` 0
  - `isr_set` 0
  - `prio_base` 0
  - `vector_ir` 7
  - `irr` 0
  - `ack_busy` 0
- **`ir_in` rise to `irr` bit:** `SYNC_STAGES` + 1 cycles (3 by default).
- **`irr` to `int_out`:** 1 cycle, giving 4 cycles total from `ir_in` rise.
- **`isr_set` / `vector_ir`:** registered; valid in the cycle after the first `inta_pulse`. `isr_set` is exactly one cycle wide.
- **`ack_busy`:** high from the cycle after the first `inta_pulse` through the cycle of the second.
- **`prio_base`:** updates the cycle after `rotate_req`.
- **`isr_cur` clear to `int_out` re-assert:** 1 cycle.

## Structure
- **Package `pic_pkg`:**
  - `NUM_IR`
  - `SPURIOUS_IR` = 3'd7
  - `ack_state_t` enum {`IDLE`, `ACK1`}
  - `rank` function (3-bit wrap subtract)
- **Sub-module `pic_prio_encoder`:** inputs a 8-bit vector and a 3-bit base; outputs `found` and a 3-bit index of the minimum-rank set bit. It is instantiated twice: once for masked IRR, once for `isr_cur`.

## Test plan
- Edge mode, base 0: pulse `ir_in`[3] high.
  - `irr`=0x08 after 3 cycles and `int_out`=1 a cycle later.
  - Two `inta_pulse`s → `isr_set`=0x08 for one cycle, `vector_ir`=3, `irr`=0.
- Requests 2 and 5 together, `isr_cur`=0x04.
  - `int_out` stays 0.
  - Clear `isr_cur` → after INTA, `vector_ir`=2; with `isr_cur`=0x04 then fed back, IR5 does not raise INT.
- `rotate_req` with `rotate_lowest`=4 (base 5), requests on 2 and 6.
  - `prio_base`=5 and the winner is 6.
  - Feed `isr_cur`=0x40; IR2 stays blocked because its rank is 5 > 1.
- Level mode: `ir_in`[1] held high, `imr`[1]=1 → `int_out` 0. Clear the mask → INT asserts. After acknowledge, `irr`[1] re-sets the next cycle.
- Withdrawn request: `ir_in`[4] rises and falls before the first INTA → `vector_ir`=7 and `isr_set`=0.
- `rst_n` low between the two INTA pulses → all outputs at reset values. A following single `inta_pulse` with a pending request is treated as a first pulse.
